// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared types and constants for the RC4 S-memory sequencer.
//   sched_state_t : phase sequencer state
//   grant_t       : S-memory owner encoding (0 none, 1 init, 2 ksa, 3 prga)
//   S_DEPTH/S_ADDR_W : S-memory geometry
//   state_owner() : which engine a given state hands the memory port to
package rc4_pkg;

  localparam int S_DEPTH  = 256;
  localparam int S_ADDR_W = 8;
  localparam int NUM_ENG  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_RUN,
    ST_KSA_GO,
    ST_KSA_RUN,
    ST_PRGA_GO,
    ST_PRGA_RUN
  } sched_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INIT = 2'd1,
    GNT_KSA  = 2'd2,
    GNT_PRGA = 2'd3
  } grant_t;

  // Ownership starts on entry to X_GO and lasts through X_RUN.
  function automatic grant_t state_owner(input sched_state_t s);
    case (s)
      ST_INIT_GO, ST_INIT_RUN: return GNT_INIT;
      ST_KSA_GO,  ST_KSA_RUN:  return GNT_KSA;
      ST_PRGA_GO, ST_PRGA_RUN: return GNT_PRGA;
      default:                 return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/s_port_mux.sv
// s_port_mux -- combinational 3-to-1 S-memory port mux.
//   sel        : owner (grant_t); GNT_NONE drives all-zero outputs
//   eng_addr   : per-engine address, [0]=init [1]=ksa [2]=prga
//   eng_wrdata : per-engine write data, same ordering
//   eng_wren   : per-engine write enable, same ordering
//   s_addr/s_wrdata/s_wren : memory port
module s_port_mux
  import rc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  grant_t                           sel,
  input  logic [NUM_ENG-1:0][ADDR_W-1:0]   eng_addr,
  input  logic [NUM_ENG-1:0][DATA_W-1:0]   eng_wrdata,
  input  logic [NUM_ENG-1:0]               eng_wren,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [DATA_W-1:0]                s_wrdata,
  output logic                             s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (sel)
      GNT_INIT: begin
        s_addr   = eng_addr[0];
        s_wrdata = eng_wrdata[0];
        s_wren   = eng_wren[0];
      end
      GNT_KSA: begin
        s_addr   = eng_addr[1];
        s_wrdata = eng_wrdata[1];
        s_wren   = eng_wren[1];
      end
      GNT_PRGA: begin
        s_addr   = eng_addr[2];
        s_wrdata = eng_wrdata[2];
        s_wren   = eng_wren[2];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_sched.sv
// rc4_sched -- RC4 phase sequencer and S-memory port arbiter.
// Runs init -> ksa -> prga once per accepted start and grants the single-port
// S memory to exactly one engine (or none).
//   clk, rst_n            : clock, async active-low reset
//   en / rdy              : start request / idle
//   {init,ksa,prga}_en    : one-cycle engine start pulses
//   {init,ksa,prga}_rdy   : engine ready/done
//   {init,ksa,prga}_addr/_wrdata/_wren : engine memory requests
//   s_addr/s_wrdata/s_wren : S-memory port (from granted engine only)
//   grant                 : owner, 0 none / 1 init / 2 ksa / 3 prga
//   err                   : sticky protocol violation; only built when
//                           RC4_SCHED_GRANT_CHECK_EN is defined, else 0
module rc4_sched
  import rc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [1:0]        grant,
  output logic              err
);

  sched_state_t state, state_d;
  grant_t       grant_q;
  logic         launch;
  // vld_pipe[0]: engine en pulse cycle, vld_pipe[1]: blank cycle after it.
  // The engine's rdy is stale in both, so RUN ignores it until the pipe drains.
  logic [1:0]   vld_pipe;
  logic         run_ok;

  logic [NUM_ENG-1:0][ADDR_W-1:0] eng_addr;
  logic [NUM_ENG-1:0][DATA_W-1:0] eng_wrdata;
  logic [NUM_ENG-1:0]             eng_wren;

  assign eng_addr   = {prga_addr,   ksa_addr,   init_addr};
  assign eng_wrdata = {prga_wrdata, ksa_wrdata, init_wrdata};
  assign eng_wren   = {prga_wren,   ksa_wren,   init_wren};

  assign run_ok = ~|vld_pipe;

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    case (state)
      ST_IDLE:     if (en) state_d = ST_INIT_GO;
      ST_INIT_GO:  if (init_rdy) begin state_d = ST_INIT_RUN; launch = 1'b1; end
      ST_INIT_RUN: if (run_ok && init_rdy) state_d = ST_KSA_GO;
      ST_KSA_GO:   if (ksa_rdy) begin state_d = ST_KSA_RUN; launch = 1'b1; end
      ST_KSA_RUN:  if (run_ok && ksa_rdy) state_d = ST_PRGA_GO;
      ST_PRGA_GO:  if (prga_rdy) begin state_d = ST_PRGA_RUN; launch = 1'b1; end
      ST_PRGA_RUN: if (run_ok && prga_rdy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant_q  <= GNT_NONE;
      vld_pipe <= '0;
    end else begin
      state    <= state_d;
      grant_q  <= state_owner(state_d);
      vld_pipe <= {vld_pipe[0], launch};
    end
  end

  assign rdy     = (state == ST_IDLE);
  assign grant   = grant_q;
  assign init_en = vld_pipe[0] && (grant_q == GNT_INIT);
  assign ksa_en  = vld_pipe[0] && (grant_q == GNT_KSA);
  assign prga_en = vld_pipe[0] && (grant_q == GNT_PRGA);

  s_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel        (grant_q),
    .eng_addr   (eng_addr),
    .eng_wrdata (eng_wrdata),
    .eng_wren   (eng_wren),
    .s_addr     (s_addr),
    .s_wrdata   (s_wrdata),
    .s_wren     (s_wren)
  );

`ifdef RC4_SCHED_GRANT_CHECK_EN
  logic [NUM_ENG-1:0] eng_rdy;
  logic [NUM_ENG-1:0] owned;
  logic               viol;
  logic               err_q;

  assign eng_rdy = {prga_rdy, ksa_rdy, init_rdy};

  always_comb begin
    owned = '0;
    case (grant_q)
      GNT_INIT: owned = 3'b001;
      GNT_KSA:  owned = 3'b010;
      GNT_PRGA: owned = 3'b100;
      default:  owned = '0;
    endcase
  end

  // A write from anyone but the owner, or an owner still claiming ready in
  // the cycle after it must have taken en, is a protocol break.
  assign viol = (|(eng_wren & ~owned)) || (vld_pipe[1] && |(eng_rdy & owned));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | viol;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_sched.sv
module tb_rc4_sched;
  import rc4_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef RC4_SCHED_GRANT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic rdy, init_en, ksa_en, prga_en;
  logic init_rdy, ksa_rdy, prga_rdy;
  logic [AW-1:0] init_addr = '0, ksa_addr = '0, prga_addr = '0;
  logic [DW-1:0] init_wrdata = '0, ksa_wrdata = '0, prga_wrdata = '0;
  logic init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wrdata;
  logic s_wren;
  logic [1:0] grant;
  logic err;

  always #5 clk = ~clk;

  rc4_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .grant(grant), .err(err)
  );

  // Stub engines: take en while ready, then stay busy for busy_len cycles.
  logic [2:0] stub_rdy;
  logic [2:0] hold = 3'b000;
  logic [2:0] eng_en;
  int         busy_cnt [3];
  int         busy_len = 256;

  assign eng_en   = {prga_en, ksa_en, init_en};
  assign init_rdy = stub_rdy[0] & ~hold[0];
  assign ksa_rdy  = stub_rdy[1] & ~hold[1];
  assign prga_rdy = stub_rdy[2] & ~hold[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_rdy <= 3'b111;
      for (int i = 0; i < 3; i++) busy_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stub_rdy[i] && !hold[i] && eng_en[i]) begin
          stub_rdy[i] <= 1'b0;
          busy_cnt[i] <= busy_len;
        end else if (!stub_rdy[i]) begin
          if (busy_cnt[i] <= 1) stub_rdy[i] <= 1'b1;
          busy_cnt[i] <= busy_cnt[i] - 1;
        end
      end
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: expected engine en order and grant transitions.
  int exp_en_q[$];
  int exp_gnt_q[$];
  logic [1:0] prev_gnt = 2'd0;

  task automatic push_run();
    exp_en_q.push_back(1); exp_en_q.push_back(2); exp_en_q.push_back(3);
    exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(3); exp_gnt_q.push_back(0);
  endtask

  always @(negedge clk) begin
    int id;
    int ex;
    if (rst_n && (init_en || ksa_en || prga_en)) begin
      id = init_en ? 1 : (ksa_en ? 2 : 3);
      ex = (exp_en_q.size() > 0) ? exp_en_q.pop_front() : 0;
      check("en_onehot", 32'($countones({init_en, ksa_en, prga_en})), 32'd1);
      check("en_seq", 32'(id), 32'(ex));
    end
    if (grant !== prev_gnt) begin
      ex = (exp_gnt_q.size() > 0) ? exp_gnt_q.pop_front() : 15;
      check("grant_seq", 32'(grant), 32'(ex));
      prev_gnt = grant;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string tag, input int max);
    int n = 0;
    while (!rdy && n < max) begin tick(); n++; end
    check(tag, 32'(rdy), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g, input int max);
    int n = 0;
    while (grant !== g && n < max) begin tick(); n++; end
    check(tag, 32'(grant), 32'(g));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    int runs;
    logic was_rdy;

    // ---- reset ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdy", 32'(rdy), 1);
    check("rst_grant", 32'(grant), 0);
    check("rst_s_wren", 32'(s_wren), 0);
    check("rst_s_addr", 32'(s_addr), 0);
    check("rst_s_wrdata", 32'(s_wrdata), 0);
    check("rst_ens", 32'({init_en, ksa_en, prga_en}), 0);
    check("rst_err", 32'(err), 0);
    #10 rst_n = 1'b1;
    tick();
    check("idle_rdy", 32'(rdy), 1);
    check("idle_grant", 32'(grant), 0);

    // ---- engine writes while idle never reach the port ----
    for (int k = 0; k < 16; k++) begin
      init_wren = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ksa_wren  = 1'($urandom_range(0, 1));
      prga_wren = 1'($urandom_range(0, 1));
      init_addr = 8'($urandom); ksa_addr = 8'($urandom); prga_addr = 8'($urandom);
      ksa_wrdata = 8'($urandom);
      #1;
      check("idle_s_wren", 32'(s_wren), 0);
      check("idle_s_addr", 32'(s_addr), 0);
      tick();
    end
    init_wren = 0; ksa_wren = 0; prga_wren = 0;
    tick();
    check("idle_err", 32'(err), 32'(CHK));
    rst_n = 1'b0;
    #1;
    check("err_cleared", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    // ---- full run, 256-cycle engines ----
    busy_len = 256;
    push_run();
    en = 1'b1;
    tick();
    en = 1'b0;
    check("start_rdy", 32'(rdy), 0);
    check("start_grant", 32'(grant), 1);
    check("start_no_en_yet", 32'(init_en), 0);
    tick();
    check("start_init_en", 32'(init_en), 1);
    wait_grant("run_ksa", 2'd2, 400);
    wait_grant("run_prga", 2'd3, 400);
    n = 0;
    while (!prga_en && n < 10) begin tick(); n++; end
    check("run_prga_en", 32'(prga_en), 1);
    n = 0;
    while (prga_rdy && n < 10) begin tick(); n++; end
    n = 0;
    while (!prga_rdy && n < 400) begin tick(); n++; end
    check("prga_rdy_seen", 32'(prga_rdy), 1);
    check("rdy_before", 32'(rdy), 0);
    tick();
    check("rdy_after_prga", 32'(rdy), 1);
    check("grant_after_prga", 32'(grant), 0);
    check("run_en_drained", 32'(exp_en_q.size()), 0);

    // ---- late init engine ----
    busy_len = 20;
    hold[0] = 1'b1;
    push_run();
    en = 1'b1;
    tick();
    en = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (init_en) seen++;
      tick();
    end
    check("late_no_en", 32'(seen), 0);
    check("late_grant", 32'(grant), 1);
    hold[0] = 1'b0;
    tick();
    check("late_en", 32'(init_en), 1);
    wait_rdy("late_done", 300);

    // ---- mux isolation during KSA ----
    busy_len = 40;
    push_run();
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_grant("iso_ksa", 2'd2, 200);
    for (int k = 0; k < 5; k++) tick();
    ksa_addr = 8'h10; ksa_wrdata = 8'hAB; ksa_wren = 1'b1;
    init_addr = 8'h20; init_wrdata = 8'h55; init_wren = 1'b1;
    #1;
    check("iso_addr", 32'(s_addr), 32'h10);
    check("iso_data", 32'(s_wrdata), 32'hAB);
    check("iso_wren", 32'(s_wren), 1);
    ksa_wren = 1'b0;
    #1;
    check("iso_blocked", 32'(s_wren), 0);
    tick();
    check("iso_err", 32'(err), 32'(CHK));
    init_wren = 1'b0;
    wait_rdy("iso_done", 300);

    // ---- en held high ----
    busy_len = 5;
    en = 1'b1;
    runs = 0;
    for (int k = 0; k < 2000; k++) begin
      was_rdy = rdy;
      if (was_rdy) begin push_run(); runs++; end
      tick();
      if (was_rdy) check("held_accept", 32'(grant), 1);
    end
    en = 1'b0;
    check("held_many_runs", 32'(runs > 20), 1);
    wait_rdy("held_done", 200);
    check("held_en_drained", 32'(exp_en_q.size()), 0);

    // ---- reset during PRGA_RUN ----
    busy_len = 256;
    push_run();
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_grant("mid_prga", 2'd3, 800);
    for (int k = 0; k < 10; k++) tick();
    prga_addr = 8'h33; prga_wrdata = 8'h77; prga_wren = 1'b1;
    #1;
    check("mid_prga_wr", 32'(s_wren), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_wren", 32'(s_wren), 0);
    check("mid_rst_addr", 32'(s_addr), 0);
    check("mid_rst_rdy", 32'(rdy), 1);
    check("mid_rst_en", 32'(prga_en), 0);
    #3 rst_n = 1'b1;
    prga_wren = 1'b0;
    tick();
    check("mid_rst_err", 32'(err), 0);
    busy_len = 20;
    push_run();
    en = 1'b1;
    tick();
    en = 1'b0;
    check("restart_grant", 32'(grant), 1);
    check("restart_rdy", 32'(rdy), 0);
    tick();
    check("restart_init_en", 32'(init_en), 1);
    wait_rdy("restart_done", 300);
    tick();

    check("sb_en_empty", 32'(exp_en_q.size()), 0);
    check("sb_gnt_empty", 32'(exp_gnt_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
